cmp_search: RTL and testbench

//   Binary-search driver sitting on the input side of a magnitude comparator.
//   It drives the probe value `guess` onto the comparator's x operand. The hidden

---
 rtl/cmp_search.sv | 78 +++++++
 tb/tb_cmp_search.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cmp_search.sv
// cmp_search: binary-search driver that recovers a hidden comparator operand
module cmp_search #(
   parameter int W = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic [W-1:0]            guess,
   input  logic                    eq,
   input  logic                    lt,
   input  logic                    gt,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [W-1:0]            result,
   output logic [$clog2(W+2)-1:0]  steps
);
   localparam int SW = $clog2(W+2);
   localparam logic [W-1:0] MAX = '1;
   localparam logic [W-1:0] ONE = 1;
   localparam logic [SW-1:0] SONE = 1;
   typedef enum logic [1:0] {IDLE, SEARCH, DONE, ERR} state_t;
   state_t state;
   logic [W-1:0] lo, hi, gp1, gm1;
   logic [2:0] f;
   assign f = {eq, lt, gt};
   assign gp1 = guess + ONE;
   assign gm1 = guess - ONE;
   // midpoint taken in W+1 bits so lo+hi never wraps
   function automatic logic [W-1:0] mid(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[W:1];
   endfunction
   // search FSM: narrows [lo,hi] on each sampled comparator response
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         guess  <= '0;
         result <= '0;
         steps  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         lo     <= '0;
         hi     <= '0;
      end else if (state != SEARCH) begin
         if (start) begin
            state <= SEARCH;
            lo    <= '0;
            hi    <= MAX;
            guess <= MAX >> 1;
            steps <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
         end
      end else begin
         steps <= steps + SONE;
         if (f == 3'b100) begin
            result <= guess;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
         end else if (f == 3'b010 && guess != hi) begin
            lo    <= gp1;
            guess <= mid(gp1, hi);
         end else if (f == 3'b001 && guess != lo) begin
            hi    <= gm1;
            guess <= mid(lo, gm1);
         end else begin
            state <= ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cmp_search.sv
// tb_cmp_search: randomized check of cmp_search against an arithmetic binary-search model
module tb_cmp_search;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [3:0] guess, result, target;
   logic eq, lt, gt, busy, done, err;
   logic [2:0] steps;
   logic ovr = 1'b0;
   logic [2:0] ovr_f = 3'b000;
   logic b_start = 1'b0;
   logic [1:0] b_guess, b_result;
   logic [1:0] b_steps;
   logic b_busy, b_done, b_err;
   logic b_eq = 1'b0;
   logic b_lt = 1'b1;
   logic b_gt = 1'b0;
   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int last_result = 0;

   always #5 clk = ~clk;

   // comparator model, optionally overridden with forced responses
   assign {eq, lt, gt} = ovr ? ovr_f : {guess == target, guess < target, guess > target};

   cmp_search #(.W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .guess(guess), .eq(eq), .lt(lt), .gt(gt),
      .busy(busy), .done(done), .err(err), .result(result), .steps(steps)
   );

   cmp_search #(.W(2)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .guess(b_guess), .eq(b_eq), .lt(b_lt), .gt(b_gt),
      .busy(b_busy), .done(b_done), .err(b_err), .result(b_result), .steps(b_steps)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // expected probe sequence from plain integer binary search over 0..15
   function automatic void model(input int t);
      int l, h, g;
      l = 0;
      h = 15;
      exp_q.delete();
      forever begin
         g = (l + h) / 2;
         exp_q.push_back(g);
         if (g == t) break;
         if (g < t) l = g + 1;
         else h = g - 1;
      end
   endfunction

   task automatic run(input int t, input bit poke);
      target = 4'(t);
      model(t);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      foreach (exp_q[k]) begin
         chk("probe", guess, exp_q[k]);
         chk("busy", busy, 1);
         chk("done_low", done, 0);
         if (poke) start = 1'b1;
         @(negedge clk) start = 1'b0;
      end
      chk("done", done, 1);
      chk("err_low", err, 0);
      chk("busy_end", busy, 0);
      chk("result", result, t);
      chk("steps", steps, exp_q.size());
      @(negedge clk);
      chk("done_hold", done, 1);
      chk("guess_hold", guess, t);
      last_result = t;
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_guess", guess, 0);
      chk("rst_result", result, 0);
      chk("rst_steps", steps, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_b_err", b_err, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      // directed targets: single probe, top and bottom of the range
      run(7, 0);
      run(15, 0);
      run(0, 0);
      // every target back to back from DONE
      for (int t = 0; t < 16; t++) run(t, 0);
      // random targets, some with start pulsed during the search
      for (int i = 0; i < 20; i++) run(int'($urandom_range(15)), 1'($urandom_range(1)));
      // eq and lt together on the first probe
      ovr = 1'b1;
      ovr_f = 3'b110;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("bad_probe", guess, 7);
      @(negedge clk);
      chk("bad_err", err, 1);
      chk("bad_busy", busy, 0);
      chk("bad_done", done, 0);
      chk("bad_steps", steps, 1);
      chk("bad_result", result, last_result);
      chk("bad_guess_hold", guess, 7);
      ovr = 1'b0;
      run(int'($urandom_range(15)), 0);
      // W=2 instance with lt stuck high walks off the top of the range
      @(negedge clk) b_start = 1'b1;
      @(negedge clk) b_start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         chk("b_probe", b_guess, k);
         chk("b_busy", b_busy, 1);
         @(negedge clk);
      end
      chk("b_err", b_err, 1);
      chk("b_busy_end", b_busy, 0);
      chk("b_done", b_done, 0);
      chk("b_steps", b_steps, 3);
      // reset with start during the second probe of a search for 15
      target = 4'd15;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("abort_p0", guess, 7);
      @(negedge clk);
      chk("abort_p1", guess, 11);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      chk("abort_guess", guess, 0);
      chk("abort_result", result, 0);
      chk("abort_steps", steps, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_err", err, 0);
      @(negedge clk);
      chk("abort_idle", busy, 0);
      run(15, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
